// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding common to uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider: one-cycle o_tick every BAUD_DIV clocks (counter wraps BAUD_DIV-1 -> 0).
module baud_tick_gen #(
  parameter int unsigned BAUD_DIV = 326
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BAUD_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_tick = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for an even-parity bit
// and the o_parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned BAUD_DIV   = 326
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_rx,
  output logic [WORD_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_done,
  output logic                  o_frame_err,
  output logic                  o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  o_parity_err
`endif
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(WORD_WIDTH + 1);
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(WORD_WIDTH - 1);

  logic rx_meta_q, rx_s, rx_prev_q;
  logic tick;

  uart_state_e           state_q;
  logic [TickW-1:0]      tick_cnt_q;
  logic [BitW-1:0]       bit_cnt_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] rx_data_q;
  logic                  rx_done_q, frame_err_q, busy_q;
`ifdef UART_RX_PARITY_EN
  logic                  parity_bit_q;
  logic                  parity_err_q;
`endif

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tick (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .o_tick (tick)
  );

  // Synchronizer idles high so reset release never looks like a start edge.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s      <= rx_meta_q;
      rx_prev_q <= rx_s;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          // Edge-triggered so a held-low (break) line cannot re-arm reception.
          if (rx_prev_q && !rx_s) begin
            state_q    <= START;
            tick_cnt_q <= '0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt_q == TickMid) begin
              if (!rx_s) begin
                state_q    <= DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt_q == TickLast) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_s, shift_q[WORD_WIDTH-1:1]};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BitLast) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick) begin
            if (tick_cnt_q == TickLast) begin
              tick_cnt_q   <= '0;
              parity_bit_q <= rx_s;
              state_q      <= STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (tick_cnt_q == TickLast) begin
              tick_cnt_q <= '0;
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              if (rx_s) begin
                rx_data_q <= shift_q;
                rx_done_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_q <= (^shift_q) ^ parity_bit_q;
`endif
              end else begin
                frame_err_q <= 1'b1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_data   = rx_data_q;
  assign o_rx_done   = rx_done_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`endif

endmodule
